vc_test_mem_responder: RTL and testbench
========================================

Name: vc_test_mem_responder

Overview:
- Single-port, word-organised test memory that acts as the responder end of the memory request/response protocol the pipelined processor issues on its imem and dmem ports.
- Accepts one request message at a time and performs the read, write or write-init against a local byte-addressed array.
- Returns a response message after a programmable latency, using val/rdy handshakes on both sides.
- Used in processor test harnesses and as a memory model behind the drop unit.

Parameters:
- p_opaque_nbits, 8, width of the opaque tag echoed from request to response.
- p_addr_nbits, 32, width of the request address.
- p_data_nbits, 32, data width. Only 32 is supported; the len field is 2 bits.
- p_mem_nbytes, 1024, memory size in bytes. Must be a power of two and ≥ 4.
- p_latency, 0, extra wait cycles between request accept and response valid (0..15).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- memreq_msg  in  77  {type[76:74], opaque[73:66], addr[65:34], len[33:32], data[31:0]}.
- memreq_val  in  1  request valid.
- memreq_rdy  out  1  request ready.
- memresp_msg  out  45  {type[44:42], opaque[41:34], len[33:32], data[31:0]}.
- memresp_val  out  1  response valid.
- memresp_rdy  in  1  response ready.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, memreq_rdy=1, memresp_val=0, memresp_msg=0, err=0, latency counter=0.
  - The memory array is NOT reset.
  - A request that is in flight or buffered is discarded.
  - Operation resumes on the first rising clk edge after reset returns to 1.
- Type codes: READ=0, WRITE=1, WRITE_INIT=2. Any other code is invalid.
- Addressing: word index = addr[log2(p_mem_nbytes)-1:2], byte offset = addr[1:0]. Upper address bits are ignored, so addresses wrap modulo p_mem_nbytes.
- Byte count: nbytes = (len==0) ? 4 : len.
- READ: data = word >> (8*offset), masked to nbytes, zero-extended.
- WRITE / WRITE_INIT: the low nbytes of request data are written to bytes offset..offset+nbytes-1. Response data = 0.
- Misaligned access (offset+nbytes > 4):
  - Only bytes inside the addressed word are accessed.
  - err is set.
  - A response is still returned.
- Invalid type: no array write, response data = 0, err set, response type echoes the request type.
- Response fields: type, opaque and len are echoed from the request.
- FSM:
  - IDLE: memreq_rdy=1. On req fire (val&rdy), the access is performed in the same edge and the response is registered. Go to RESP if p_latency==0; otherwise load the counter with p_latency and go to WAIT.
  - WAIT: memreq_rdy=0, memresp_val=0. Counter decrements each cycle; on the count==1 edge go to RESP.
  - RESP: memresp_val=1 and memresp_msg is held stable. On resp fire go to IDLE. No bypass: the next request is accepted no earlier than the cycle after resp fire.
- Latency: response valid p_latency+1 cycles after the accept edge. Throughput is at most one transaction per 2 cycles when p_latency=0.
- Backpressure: RESP holds indefinitely while memresp_rdy=0; the message must not change.
- Read-after-write: a write updates the array at its accept edge, so a subsequent read sees the new data.
- err clears only on reset.

Decomposition:
- Shared package vc_mem_msg_pkg holds:
  - type codes READ/WRITE/WRITE_INIT;
  - field widths and bit positions for the 77-bit request and 45-bit response;
  - a packed struct for each message.
- One sub-module, vc_mem_byte_lane: combinational read extract (word, offset, len → data) and write merge (word, offset, len, data → new word, misalign flag). It is shared with future cache models.
- The FSM and latency counter live in the top module.

Test Plan:
- Word write then read: WRITE addr=0x1000 len=0 data=0xDEADBEEF opaque=0x05, then READ addr=0x1000 len=0 → resp {WRITE,0x05,0,0x0}, then {READ,_,0,0xDEADBEEF}.
- Subword: WRITE addr=0x1002 len=1 data=0x000000AA over 0x11223344, then READ addr=0x1000 len=0 → 0x11AA3344; READ addr=0x1002 len=1 → 0x000000AA.
- Latency and backpressure: p_latency=3, READ accepted at cycle t → memresp_val rises at t+4. Hold memresp_rdy=0 for 5 cycles → msg stable and memreq_rdy=0 throughout.
- Misaligned: READ addr=0x1003 len=2 → response returned with only byte 3 in data[7:0]; err=1 and stays 1.
- Wrap: p_mem_nbytes=1024, WRITE addr=0x0404 data=0x12345678, then READ addr=0x0004 → 0x12345678.
- Reset mid-WAIT: p_latency=5, assert reset 2 cycles after accept → memresp_val=0 immediately, memreq_rdy=1 after release, no stale response ever appears.

Source files
------------

// File: rtl/vc_mem_msg_pkg.sv
// Shared definitions for the memory request/response messages: type codes,
// field widths, bit positions, packed message structs and the responder FSM states.
package vc_mem_msg_pkg;

    localparam int TYPE_NBITS   = 3;
    localparam int OPAQUE_NBITS = 8;
    localparam int ADDR_NBITS   = 32;
    localparam int LEN_NBITS    = 2;
    localparam int DATA_NBITS   = 32;

    localparam int REQ_NBITS  = TYPE_NBITS + OPAQUE_NBITS + ADDR_NBITS + LEN_NBITS + DATA_NBITS;
    localparam int RESP_NBITS = TYPE_NBITS + OPAQUE_NBITS + LEN_NBITS + DATA_NBITS;

    localparam int REQ_DATA_LSB   = 0;
    localparam int REQ_LEN_LSB    = 32;
    localparam int REQ_ADDR_LSB   = 34;
    localparam int REQ_OPAQUE_LSB = 66;
    localparam int REQ_TYPE_LSB   = 74;

    localparam int RESP_DATA_LSB   = 0;
    localparam int RESP_LEN_LSB    = 32;
    localparam int RESP_OPAQUE_LSB = 34;
    localparam int RESP_TYPE_LSB   = 42;

    localparam logic [2:0] MEM_TYPE_READ       = 3'd0;
    localparam logic [2:0] MEM_TYPE_WRITE      = 3'd1;
    localparam logic [2:0] MEM_TYPE_WRITE_INIT = 3'd2;

    typedef struct packed {
        logic [TYPE_NBITS-1:0]   typ;
        logic [OPAQUE_NBITS-1:0] opaque;
        logic [ADDR_NBITS-1:0]   addr;
        logic [LEN_NBITS-1:0]    len;
        logic [DATA_NBITS-1:0]   data;
    } mem_req_msg_t;

    typedef struct packed {
        logic [TYPE_NBITS-1:0]   typ;
        logic [OPAQUE_NBITS-1:0] opaque;
        logic [LEN_NBITS-1:0]    len;
        logic [DATA_NBITS-1:0]   data;
    } mem_resp_msg_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } resp_state_e;

    // A len of zero means a full 4-byte word.
    function automatic logic [2:0] len_to_nbytes(input logic [1:0] len);
        return (len == 2'd0) ? 3'd4 : {1'b0, len};
    endfunction

endpackage

// File: rtl/vc_mem_byte_lane.sv
// Byte-lane helper for a 32-bit word: extracts read data at a byte offset and
// merges write data into a word, flagging accesses that spill past the word.
module vc_mem_byte_lane
    import vc_mem_msg_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  len,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] wword,
    output logic        misalign
);

    logic [2:0]  nbytes;
    logic [2:0]  first;
    logic [2:0]  last_excl;
    logic [31:0] rshift;
    logic [31:0] wshift;

    always_comb begin
        nbytes    = len_to_nbytes(len);
        first     = {1'b0, offset};
        last_excl = first + nbytes;
        misalign  = (last_excl > 3'd4);
        rshift    = word >> {offset, 3'b000};
        wshift    = wdata << {offset, 3'b000};
        rdata     = '0;
        wword     = word;
        // Bytes beyond the word shift in as zero, so a spilling read is clipped naturally.
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < nbytes) begin
                rdata[8*i +: 8] = rshift[8*i +: 8];
            end
            if ((3'(i) >= first) && (3'(i) < last_excl)) begin
                wword[8*i +: 8] = wshift[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/vc_test_mem_responder.sv
// Test memory responder: accepts one memory request at a time, performs it on a
// local word array and returns the response after a fixed programmable latency.
module vc_test_mem_responder
    import vc_mem_msg_pkg::*;
#(
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 32,
    parameter int p_mem_nbytes   = 1024,
    parameter int p_latency      = 0
)
(
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic [p_opaque_nbits+p_addr_nbits+p_data_nbits+4:0] memreq_msg,
    input  logic                                              memreq_val,
    output logic                                              memreq_rdy,
    output logic [p_opaque_nbits+p_data_nbits+4:0]              memresp_msg,
    output logic                                              memresp_val,
    input  logic                                              memresp_rdy,
    output logic                                              err
);

    localparam int         NWORDS   = p_mem_nbytes / 4;
    localparam int         IDX_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int         REQ_MSB  = p_opaque_nbits + p_addr_nbits + p_data_nbits + 4;
    localparam int         RESP_MSB = p_opaque_nbits + p_data_nbits + 4;
    localparam logic [3:0] LAT      = 4'(p_latency);

    // Handshake: a transfer happens on a rising edge where val and rdy are both high;
    // val never waits on rdy, and a valid message stays unchanged until it transfers.

    logic [2:0]                req_type;
    logic [p_opaque_nbits-1:0] req_opaque;
    logic [p_addr_nbits-1:0]   req_addr;
    logic [1:0]                req_len;
    logic [31:0]               req_data;

    assign req_type   = memreq_msg[REQ_MSB -: 3];
    assign req_opaque = memreq_msg[p_data_nbits + 2 + p_addr_nbits +: p_opaque_nbits];
    assign req_addr   = memreq_msg[p_data_nbits + 2 +: p_addr_nbits];
    assign req_len    = memreq_msg[p_data_nbits +: 2];
    assign req_data   = memreq_msg[31:0];

    logic [31:0]      mem_q [NWORDS];
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      rd_word;
    logic [31:0]      lane_rdata;
    logic [31:0]      lane_wword;
    logic             lane_misalign;
    logic             mem_we;
    logic             is_read;
    logic             is_write;

    // Upper address bits drop out here, so addresses wrap modulo the memory size.
    assign word_idx = IDX_W'(req_addr >> 2) & IDX_W'(NWORDS - 1);
    assign rd_word  = mem_q[word_idx];
    assign is_read  = (req_type == MEM_TYPE_READ);
    assign is_write = (req_type == MEM_TYPE_WRITE) || (req_type == MEM_TYPE_WRITE_INIT);

    vc_mem_byte_lane u_lane (
        .word     (rd_word),
        .offset   (req_addr[1:0]),
        .len      (req_len),
        .wdata    (req_data),
        .rdata    (lane_rdata),
        .wword    (lane_wword),
        .misalign (lane_misalign)
    );

    resp_state_e            state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [RESP_MSB:0]      resp_q, resp_d;
    logic                   err_q, err_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        resp_d      = resp_q;
        err_d       = err_q;
        mem_we      = 1'b0;
        memreq_rdy  = 1'b0;
        memresp_val = 1'b0;
        case (state_q)
            ST_IDLE: begin
                memreq_rdy = 1'b1;
                if (memreq_val) begin
                    mem_we = is_write;
                    resp_d = {req_type, req_opaque, req_len, is_read ? lane_rdata : 32'd0};
                    err_d  = err_q | lane_misalign | ~(is_read | is_write);
                    if (LAT == 4'd0) begin
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = LAT;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                memresp_val = 1'b1;
                if (memresp_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            resp_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end

    // The array keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[word_idx] <= lane_wword;
        end
    end

    assign memresp_msg = resp_q;
    assign err         = err_q;

endmodule

// File: tb/tb_vc_test_mem_responder.sv
// Directed bench for vc_test_mem_responder using three instances with latency 0, 3 and 5.
module tb_vc_test_mem_responder;
  import vc_mem_msg_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [76:0] req_msg  [3];
  logic        req_val  [3];
  logic        req_rdy  [3];
  logic [44:0] resp_msg [3];
  logic        resp_val [3];
  logic        resp_rdy [3];
  logic        err      [3];

  int errors = 0;
  int checks = 0;

  vc_test_mem_responder #(.p_latency(0)) dut_l0 (
    .clk(clk), .reset(rst_n),
    .memreq_msg(req_msg[0]), .memreq_val(req_val[0]), .memreq_rdy(req_rdy[0]),
    .memresp_msg(resp_msg[0]), .memresp_val(resp_val[0]), .memresp_rdy(resp_rdy[0]),
    .err(err[0])
  );

  vc_test_mem_responder #(.p_latency(3)) dut_l3 (
    .clk(clk), .reset(rst_n),
    .memreq_msg(req_msg[1]), .memreq_val(req_val[1]), .memreq_rdy(req_rdy[1]),
    .memresp_msg(resp_msg[1]), .memresp_val(resp_val[1]), .memresp_rdy(resp_rdy[1]),
    .err(err[1])
  );

  vc_test_mem_responder #(.p_latency(5)) dut_l5 (
    .clk(clk), .reset(rst_n),
    .memreq_msg(req_msg[2]), .memreq_val(req_val[2]), .memreq_rdy(req_rdy[2]),
    .memresp_msg(resp_msg[2]), .memresp_val(resp_val[2]), .memresp_rdy(resp_rdy[2]),
    .err(err[2])
  );

  function automatic int lat_of(input int k);
    case (k)
      0: return 0;
      1: return 3;
      default: return 5;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction on instance k; hold = cycles of response backpressure.
  task automatic txn(input int k, input logic [2:0] typ, input logic [7:0] op,
                     input logic [31:0] addr, input logic [1:0] len, input logic [31:0] data,
                     input logic [31:0] exp_data, input int hold);
    int n;
    logic [44:0] exp_resp;
    exp_resp = {typ, op, len, exp_data};
    @(negedge clk);
    req_msg[k] = {typ, op, addr, len, data};
    req_val[k] = 1'b1;
    n = 0;
    while (req_rdy[k] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_rdy_idle", 64'(req_rdy[k]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_val[k] = 1'b0;
    n = 1;
    while (resp_val[k] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(lat_of(k) + 1));
    chk("resp_msg", 64'(resp_msg[k]), 64'(exp_resp));
    chk("req_rdy_busy", 64'(req_rdy[k]), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_msg_stable", 64'(resp_msg[k]), 64'(exp_resp));
      chk("bp_resp_val", 64'(resp_val[k]), 64'd1);
      chk("bp_req_rdy", 64'(req_rdy[k]), 64'd0);
    end
    resp_rdy[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_rdy[k] = 1'b0;
    chk("resp_val_drop", 64'(resp_val[k]), 64'd0);
    chk("req_rdy_back", 64'(req_rdy[k]), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stale;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_msg[k]  = '0;
      req_val[k]  = 1'b0;
      resp_rdy[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_req_rdy", 64'(req_rdy[0]), 64'd1);
    chk("rst_resp_val", 64'(resp_val[0]), 64'd0);
    chk("rst_resp_msg", 64'(resp_msg[0]), 64'd0);
    chk("rst_err", 64'(err[0]), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Word write then read back
    txn(0, MEM_TYPE_WRITE, 8'h05, 32'h1000, 2'd0, 32'hDEADBEEF, 32'h0, 0);
    txn(0, MEM_TYPE_READ,  8'h06, 32'h1000, 2'd0, 32'h0, 32'hDEADBEEF, 0);

    // Subword write into 0x11223344
    txn(0, MEM_TYPE_WRITE, 8'h07, 32'h1000, 2'd0, 32'h11223344, 32'h0, 0);
    txn(0, MEM_TYPE_WRITE, 8'h08, 32'h1002, 2'd1, 32'h000000AA, 32'h0, 0);
    txn(0, MEM_TYPE_READ,  8'h09, 32'h1000, 2'd0, 32'h0, 32'h11AA3344, 0);
    txn(0, MEM_TYPE_READ,  8'h0A, 32'h1002, 2'd1, 32'h0, 32'h000000AA, 0);
    txn(0, MEM_TYPE_READ,  8'h0B, 32'h1001, 2'd2, 32'h0, 32'h0000AA33, 0);
    chk("err_clean", 64'(err[0]), 64'd0);

    // Address wrap and write-init
    txn(0, MEM_TYPE_WRITE,      8'h0C, 32'h0404, 2'd0, 32'h12345678, 32'h0, 0);
    txn(0, MEM_TYPE_READ,       8'h0D, 32'h0004, 2'd0, 32'h0, 32'h12345678, 0);
    txn(0, MEM_TYPE_WRITE_INIT, 8'h0E, 32'h0008, 2'd0, 32'hCAFEF00D, 32'h0, 0);
    txn(0, MEM_TYPE_READ,       8'h0F, 32'h0008, 2'd0, 32'h0, 32'hCAFEF00D, 0);
    chk("err_still_clean", 64'(err[0]), 64'd0);

    // Misaligned read, then misaligned write clipped to the word
    txn(0, MEM_TYPE_READ,  8'h10, 32'h1003, 2'd2, 32'h0, 32'h00000011, 0);
    chk("err_misalign", 64'(err[0]), 64'd1);
    txn(0, MEM_TYPE_WRITE, 8'h11, 32'h000B, 2'd3, 32'h00776655, 32'h0, 0);
    txn(0, MEM_TYPE_READ,  8'h12, 32'h0008, 2'd0, 32'h0, 32'h55FEF00D, 0);
    chk("err_sticky", 64'(err[0]), 64'd1);

    // Invalid type: echoed, data zero, no array write
    txn(0, 3'd5,          8'h13, 32'h0008, 2'd0, 32'hFFFFFFFF, 32'h0, 0);
    txn(0, MEM_TYPE_READ, 8'h14, 32'h0008, 2'd0, 32'h0, 32'h55FEF00D, 0);
    chk("err_after_invalid", 64'(err[0]), 64'd1);

    // Latency 3 with 5 cycles of backpressure
    txn(1, MEM_TYPE_WRITE, 8'h20, 32'h0020, 2'd0, 32'hA5A50F0F, 32'h0, 0);
    txn(1, MEM_TYPE_READ,  8'h21, 32'h0020, 2'd0, 32'h0, 32'hA5A50F0F, 5);
    chk("l3_err", 64'(err[1]), 64'd0);

    // Reset two cycles into a latency-5 wait
    @(negedge clk);
    req_msg[2] = {MEM_TYPE_READ, 8'h33, 32'h0, 2'd0, 32'h0};
    req_val[2] = 1'b1;
    chk("l5_req_rdy", 64'(req_rdy[2]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_val[2] = 1'b0;
    chk("l5_wait_val", 64'(resp_val[2]), 64'd0);
    chk("l5_wait_rdy", 64'(req_rdy[2]), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_val", 64'(resp_val[2]), 64'd0);
    chk("rst_async_rdy", 64'(req_rdy[2]), 64'd1);
    chk("rst_async_msg", 64'(resp_msg[2]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (resp_val[2] !== 1'b0 || req_rdy[2] !== 1'b1) stale++;
    end
    chk("no_stale_resp", 64'(stale), 64'd0);
    chk("err_cleared", 64'(err[0]), 64'd0);

    // Array contents survive reset; latency-5 instance resumes
    txn(0, MEM_TYPE_READ,  8'h40, 32'h1000, 2'd0, 32'h0, 32'h11AA3344, 0);
    txn(2, MEM_TYPE_WRITE, 8'h41, 32'h0010, 2'd0, 32'h01020304, 32'h0, 0);
    txn(2, MEM_TYPE_READ,  8'h42, 32'h0010, 2'd0, 32'h0, 32'h01020304, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
